// File: rtl/proc_data_responder.sv
// Data-port responder: word RAM plus an MMIO window (cycle counter, TX FIFO, drop counter).
// Every access is answered combinationally in the cycle it is presented.
module proc_data_responder #(
    parameter int          DEPTH      = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [31:0] DATA_ADDR,
    input  logic [31:0] DATA_WDATA,
    input  logic        DATA_WRITE,
    output logic [31:0] DATA_RDATA,
    output logic [31:0] TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [9:0] OFF_CYCLE = 10'd0;
    localparam logic [9:0] OFF_TX    = 10'd1;
    localparam logic [9:0] OFF_DROP  = 10'd2;

    logic [31:0]   r_ram [DEPTH];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [31:0]   r_cycle;
    logic [15:0]   r_drop;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_in_ram;
    logic          w_in_mmio;
    logic [9:0]    w_off;
    logic [AW-1:0] w_ram_idx;
    logic          w_wr_ram;
    logic          w_wr_cycle;
    logic          w_push_req;
    logic          w_wr_drop;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [7:0]    w_count8;

    assign w_in_ram   = (DATA_ADDR >> (AW + 2)) == 32'd0;
    assign w_in_mmio  = DATA_ADDR[31:12] == MMIO_BASE[31:12];
    assign w_off      = DATA_ADDR[11:2];
    assign w_ram_idx  = DATA_ADDR[AW+1:2];

    assign w_wr_ram   = DATA_WRITE && w_in_ram;
    assign w_wr_cycle = DATA_WRITE && w_in_mmio && (w_off == OFF_CYCLE);
    assign w_push_req = DATA_WRITE && w_in_mmio && (w_off == OFF_TX);
    assign w_wr_drop  = DATA_WRITE && w_in_mmio && (w_off == OFF_DROP);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_pop      = !w_empty && TX_READY;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_count8   = 8'(r_count);

    assign TX_VALID   = !w_empty;
    assign TX_DATA    = w_empty ? 32'd0 : r_fifo[r_rptr];

    always_ff @(posedge CLK) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= DATA_WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wptr] <= DATA_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_cycle <= '0;
            r_drop  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_cycle <= w_wr_cycle ? 32'd0 : r_cycle + 32'd1;

            if (w_wr_drop) begin
                r_drop <= '0;
            end else if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end

            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_comb begin
        DATA_RDATA = 32'd0;
        if (w_in_ram) begin
            DATA_RDATA = r_ram[w_ram_idx];
        end else if (w_in_mmio) begin
            case (w_off)
                OFF_CYCLE: DATA_RDATA = r_cycle;
                OFF_TX:    DATA_RDATA = {16'd0, w_count8, 6'd0, w_full, w_empty};
                OFF_DROP:  DATA_RDATA = {16'd0, r_drop};
                default:   DATA_RDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_data_responder.sv
// Bench for proc_data_responder: directed scenarios plus random traffic,
// all checked against a queue/array model of the memory map.
module tb_proc_data_responder;

    localparam int          DEPTH = 1024;
    localparam int          FD    = 8;
    localparam logic [31:0] BASE  = 32'hFFFF0000;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic [31:0] DATA_ADDR = '0;
    logic [31:0] DATA_WDATA = '0;
    logic        DATA_WRITE = 1'b0;
    logic        TX_READY = 1'b0;
    logic [31:0] DATA_RDATA;
    logic [31:0] TX_DATA;
    logic        TX_VALID;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_ram [int];
    logic [31:0] m_cycle;
    logic [31:0] m_q [$];
    int          m_drop;

    proc_data_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .DATA_ADDR  (DATA_ADDR),
        .DATA_WDATA (DATA_WDATA),
        .DATA_WRITE (DATA_WRITE),
        .DATA_RDATA (DATA_RDATA),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic bit m_is_mmio(input logic [31:0] a);
        return (a >> 12) == (BASE >> 12);
    endfunction

    function automatic bit m_known(input logic [31:0] a);
        if (a < 32'(DEPTH * 4)) return m_ram.exists(int'(a >> 2));
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int n;
        n = m_q.size();
        if (a < 32'(DEPTH * 4)) begin
            if (m_ram.exists(int'(a >> 2))) return m_ram[int'(a >> 2)];
            return 32'd0;
        end
        if (m_is_mmio(a)) begin
            case ((a & 32'h0000_0FFC))
                32'h000: return m_cycle;
                32'h004: return {16'd0, 8'(n), 6'd0, (n == FD), (n == 0)};
                32'h008: return {16'd0, 16'(m_drop)};
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] status(input int n);
        return {16'd0, 8'(n), 6'd0, (n == FD), (n == 0)};
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic w, input logic rdy);
        DATA_ADDR  = a;
        DATA_WDATA = d;
        DATA_WRITE = w;
        TX_READY   = rdy;
    endtask

    task automatic model_reset();
        m_cycle = '0;
        m_drop  = 0;
        m_q.delete();
    endtask

    // One clock edge: advance the model from the inputs held across the edge.
    task automatic tick();
        int n;
        bit pop;
        bit mm;
        logic [31:0] off;
        @(posedge CLK);
        n   = m_q.size();
        pop = (n != 0) && TX_READY;
        mm  = m_is_mmio(DATA_ADDR);
        off = DATA_ADDR & 32'h0000_0FFC;
        if (DATA_WRITE && DATA_ADDR < 32'(DEPTH * 4)) m_ram[int'(DATA_ADDR >> 2)] = DATA_WDATA;
        if (DATA_WRITE && mm && off == 32'h000) m_cycle = '0;
        else m_cycle = m_cycle + 32'd1;
        if (pop) void'(m_q.pop_front());
        if (DATA_WRITE && mm && off == 32'h004) begin
            if (n < FD || pop) m_q.push_back(DATA_WDATA);
            else if (m_drop < 65535) m_drop++;
        end
        if (DATA_WRITE && mm && off == 32'h008) m_drop = 0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        NRST = 1'b0;
        apply(BASE, 0, 0, 0);
        @(negedge CLK);
        #1;
        checks++;
        if (TX_VALID !== 1'b0 || TX_DATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_tx valid=%b data=%h exp valid=0 data=0", TX_VALID, TX_DATA);
        end
        checks++;
        if (DATA_RDATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycle got %h exp 00000000", DATA_RDATA);
        end
        apply(BASE + 4, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_status got %h exp 00000001", DATA_RDATA);
        end
        apply(BASE + 8, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_drop got %h exp 00000000", DATA_RDATA);
        end
        @(negedge CLK);
        NRST = 1'b1;
        model_reset();
    endtask

    task automatic test_cycle();
        apply(BASE, 0, 0, 0);
        repeat (5) tick();
        #1;
        checks++;
        if (DATA_RDATA !== 32'd5 || DATA_RDATA !== m_cycle) begin
            errors++;
            $display("FAIL cycle_after5 got %h exp 00000005", DATA_RDATA);
        end
        apply(BASE, 32'h1234_ABCD, 1, 0);
        tick();
        apply(BASE, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'd0) begin
            errors++;
            $display("FAIL cycle_clear got %h exp 00000000", DATA_RDATA);
        end
        tick();
        #1;
        checks++;
        if (DATA_RDATA !== 32'd1) begin
            errors++;
            $display("FAIL cycle_after_clear got %h exp 00000001", DATA_RDATA);
        end
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (DATA_RDATA !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL cycle_max_read got %h exp ffffffff", DATA_RDATA);
        end
        release dut.r_cycle;
        m_cycle = 32'hFFFF_FFFF;
        tick();
        #1;
        checks++;
        if (DATA_RDATA !== 32'd0 || m_cycle !== 32'd0) begin
            errors++;
            $display("FAIL cycle_wrap got %h exp 00000000", DATA_RDATA);
        end
    endtask

    task automatic test_ram();
        apply(32'h10, 32'h1111_1111, 1, 0);
        tick();
        apply(32'h0, 32'h5A5A_0000, 1, 0);
        tick();
        apply(32'h10, 32'hDEAD_BEEF, 1, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h1111_1111 || DATA_RDATA !== m_read(32'h10)) begin
            errors++;
            $display("FAIL ram_same_cycle got %h exp 11111111", DATA_RDATA);
        end
        tick();
        apply(32'h10, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_next_cycle got %h exp deadbeef", DATA_RDATA);
        end
        apply(32'h13, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_byte_ignored got %h exp deadbeef", DATA_RDATA);
        end
        apply(32'(DEPTH * 4), 32'h7777_7777, 1, 0);
        tick();
        apply(32'(DEPTH * 4), 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'd0) begin
            errors++;
            $display("FAIL hole_read got %h exp 00000000", DATA_RDATA);
        end
        apply(32'h0, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h5A5A_0000) begin
            errors++;
            $display("FAIL hole_no_alias got %h exp 5a5a0000", DATA_RDATA);
        end
    endtask

    task automatic test_fifo_fill();
        for (int i = 1; i <= 8; i++) begin
            apply(BASE + 4, 32'(i), 1, 0);
            tick();
        end
        apply(BASE + 4, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h0000_0802) begin
            errors++;
            $display("FAIL fifo_full_status got %h exp 00000802", DATA_RDATA);
        end
        apply(BASE + 4, 32'd9, 1, 0);
        tick();
        apply(BASE + 8, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'd1 || DATA_RDATA !== m_read(BASE + 8)) begin
            errors++;
            $display("FAIL drop_one got %h exp 00000001", DATA_RDATA);
        end
        apply(BASE + 4, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++;
            if (TX_VALID !== 1'b1 || TX_DATA !== 32'(i)) begin
                errors++;
                $display("FAIL drain_seq[%0d] valid=%b data=%h exp valid=1 data=%h", i, TX_VALID, TX_DATA, 32'(i));
            end
            tick();
        end
        #1;
        checks++;
        if (TX_VALID !== 1'b0 || DATA_RDATA !== 32'h0000_0001) begin
            errors++;
            $display("FAIL drain_empty valid=%b status=%h exp valid=0 status=00000001", TX_VALID, DATA_RDATA);
        end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp_seq [8];
        int drop_before;
        for (int i = 1; i <= 8; i++) begin
            apply(BASE + 4, 32'h100 + 32'(i), 1, 0);
            tick();
        end
        drop_before = m_drop;
        apply(BASE + 4, 32'hA5, 1, 1);
        #1;
        checks++;
        if (TX_DATA !== 32'h101) begin
            errors++;
            $display("FAIL pp_head got %h exp 00000101", TX_DATA);
        end
        tick();
        apply(BASE + 4, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h0000_0802) begin
            errors++;
            $display("FAIL pp_count got %h exp 00000802", DATA_RDATA);
        end
        apply(BASE + 8, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'(drop_before)) begin
            errors++;
            $display("FAIL pp_no_drop got %h exp %h", DATA_RDATA, 32'(drop_before));
        end
        for (int i = 0; i < 7; i++) exp_seq[i] = 32'h102 + 32'(i);
        exp_seq[7] = 32'hA5;
        apply(BASE + 4, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (TX_VALID !== 1'b1 || TX_DATA !== exp_seq[i] || TX_DATA !== m_q[0]) begin
                errors++;
                $display("FAIL pp_seq[%0d] valid=%b data=%h exp %h", i, TX_VALID, TX_DATA, exp_seq[i]);
            end
            tick();
        end
        #1;
        checks++;
        if (TX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL pp_empty valid=%b exp 0", TX_VALID);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            apply(BASE + 4, 32'hC0 + 32'(i), 1, 0);
            tick();
        end
        apply(BASE, 0, 0, 0);
        #1;
        checks++;
        if (TX_VALID !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid got %b exp 1", TX_VALID);
        end
        #1;
        NRST = 1'b0;
        #1;
        checks++;
        if (TX_VALID !== 1'b0 || TX_DATA !== 32'd0 || DATA_RDATA !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset valid=%b data=%h cycle=%h exp 0/0/0", TX_VALID, TX_DATA, DATA_RDATA);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (DATA_RDATA !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_hold cycle=%h exp 00000000", DATA_RDATA);
        end
        @(negedge CLK);
        NRST = 1'b1;
        model_reset();
        apply(BASE + 4, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mid_release_status got %h exp 00000001", DATA_RDATA);
        end
        tick();
        apply(BASE, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'd1) begin
            errors++;
            $display("FAIL mid_first_inc got %h exp 00000001", DATA_RDATA);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        int          sel;
        for (int it = 0; it < 400; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 4) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            else if (sel == 5) a = BASE;
            else if (sel <= 7) a = BASE + 4;
            else if (sel == 8) a = ($urandom_range(0, 1) != 0) ? BASE + 8 : BASE + 32'hC;
            else a = ($urandom_range(0, 1) != 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4) : 32'h8000_0000;
            d = $urandom;
            w = (sel == 5) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) != 0);
            apply(a, d, w, $urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (TX_VALID !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid[%0d] got %b exp %b", it, TX_VALID, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (TX_DATA !== m_q[0]) begin
                    errors++;
                    $display("FAIL rnd_txdata[%0d] got %h exp %h", it, TX_DATA, m_q[0]);
                end
            end
            if (m_known(a)) begin
                checks++;
                if (DATA_RDATA !== m_read(a)) begin
                    errors++;
                    $display("FAIL rnd_rdata[%0d] addr=%h got %h exp %h", it, a, DATA_RDATA, m_read(a));
                end
            end
            tick();
        end
    endtask

    task automatic test_drop_sat();
        apply(BASE + 8, 0, 1, 0);
        tick();
        while (m_q.size() < FD) begin
            apply(BASE + 4, $urandom, 1, 0);
            tick();
        end
        apply(BASE + 4, 32'hEEEE_EEEE, 1, 0);
        repeat (65534) tick();
        apply(BASE + 8, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h0000_FFFE || DATA_RDATA !== m_read(BASE + 8)) begin
            errors++;
            $display("FAIL drop_fffe got %h exp 0000fffe", DATA_RDATA);
        end
        apply(BASE + 4, 32'hEEEE_EEEE, 1, 0);
        repeat (6) tick();
        apply(BASE + 8, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL drop_sat got %h exp 0000ffff", DATA_RDATA);
        end
        apply(BASE + 4, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== status(FD)) begin
            errors++;
            $display("FAIL drop_fifo_unchanged got %h exp %h", DATA_RDATA, status(FD));
        end
        apply(BASE + 8, 32'h55, 1, 0);
        tick();
        apply(BASE + 8, 0, 0, 0);
        #1;
        checks++;
        if (DATA_RDATA !== 32'd0) begin
            errors++;
            $display("FAIL drop_clear got %h exp 00000000", DATA_RDATA);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cycle();
        test_ram();
        test_fifo_fill();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        test_drop_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
